// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
//   Shared constants and types for the RV32 core's register-file helpers.
//
//   Contents:
//     Xlen, RegAw, NumRegs       - datapath width, register address width, count
//     DefFirstReg, DefLastReg    - default index range for the loader (x0 is
//                                  hardwired zero and never written)
//     loader_state_e             - state encoding of regfile_loader
//     reg_idx()                  - narrows an integer index to a register address
// ----------------------------------------------------------------------------
package rv32_pkg;

   localparam int unsigned Xlen    = 32;
   localparam int unsigned RegAw   = 5;
   localparam int unsigned NumRegs = 32;

   localparam int unsigned DefFirstReg = 1;
   localparam int unsigned DefLastReg  = 31;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StLoad     = 3'd1,
      StDumpRd   = 3'd2,
      StDumpWait = 3'd3,
      StDone     = 3'd4
   } loader_state_e;

   function automatic logic [RegAw-1:0] reg_idx(input int unsigned n);
      return RegAw'(n);
   endfunction

endpackage

// File: rtl/regfile_loader.sv
// ----------------------------------------------------------------------------
// regfile_loader
//   Bulk load / dump engine for the integer register file. It sits beside the
//   register file; while busy is high the core is stalled and the write port
//   is muxed over to rf_a3/rf_wd3/rf_we.
//
//   Load: a valid/ready stream of 32-bit words is written, one per accepted
//   beat, to registers FIRST_REG..LAST_REG in ascending order. The write is
//   registered (it appears the cycle after the beat is accepted).
//
//   Dump: registers FIRST_REG..LAST_REG are read through the combinational
//   read port (rf_a1 -> rf_rd1) and presented on a valid/ready stream. Each
//   word takes a read cycle and a present cycle, so at most one word per two
//   cycles leaves the block.
//
//   Ports:
//     clk                      sole clock, rising edge
//     reset                    synchronous, active low
//     start_load, start_dump   one-cycle requests, honoured only when idle;
//                              load wins if both are raised together
//     abort                    returns to idle next cycle, no done pulse
//     in_valid/in_data/in_ready     load stream
//     out_valid/out_data/out_ready  dump stream
//     rf_a3/rf_wd3/rf_we       register-file write port drive
//     rf_a1/rf_rd1             register-file read address / read data
//     busy                     high while an operation is in progress
//     done                     one-cycle completion pulse
// ----------------------------------------------------------------------------
module regfile_loader
   import rv32_pkg::*;
#(
   parameter int unsigned FIRST_REG = DefFirstReg,
   parameter int unsigned LAST_REG  = DefLastReg
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             start_load,
   input  logic             start_dump,
   input  logic             abort,

   input  logic             in_valid,
   input  logic [Xlen-1:0]  in_data,
   output logic             in_ready,

   output logic             out_valid,
   output logic [Xlen-1:0]  out_data,
   input  logic             out_ready,

   output logic [RegAw-1:0] rf_a3,
   output logic [Xlen-1:0]  rf_wd3,
   output logic             rf_we,

   output logic [RegAw-1:0] rf_a1,
   input  logic [Xlen-1:0]  rf_rd1,

   output logic             busy,
   output logic             done
);

   localparam logic [RegAw-1:0] FirstIdx = reg_idx(FIRST_REG);
   localparam logic [RegAw-1:0] LastIdx  = reg_idx(LAST_REG);

   loader_state_e    state;
   logic [RegAw-1:0] idx;

   logic beat_acc;
   logic at_last;

   // in_ready is only ever high in StLoad, so this is the load handshake.
   assign beat_acc = in_valid && in_ready;
   assign at_last  = (idx == LastIdx);

   // The read port always points at the current index; in dump mode the
   // register file answers combinationally in the same cycle.
   assign rf_a1 = idx;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= StIdle;
         idx       <= FirstIdx;
         busy      <= 1'b0;
         done      <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         rf_we     <= 1'b0;
         rf_a3     <= '0;
         rf_wd3    <= '0;
      end else if (abort) begin
         // A beat accepted in this same cycle never reaches the register file.
         state     <= StIdle;
         idx       <= FirstIdx;
         busy      <= 1'b0;
         done      <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         rf_we     <= 1'b0;
      end else begin
         rf_we <= 1'b0;
         done  <= 1'b0;

         unique case (state)
            StIdle: begin
               busy <= 1'b0;
               // While done is high the previous operation is still being
               // reported; the core is stalled so no start is expected.
               if (!done) begin
                  if (start_load) begin
                     state    <= StLoad;
                     idx      <= FirstIdx;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                  end else if (start_dump) begin
                     state <= StDumpRd;
                     idx   <= FirstIdx;
                     busy  <= 1'b1;
                  end
               end
            end

            StLoad: begin
               if (beat_acc) begin
                  rf_we  <= 1'b1;
                  rf_a3  <= idx;
                  rf_wd3 <= in_data;
                  if (at_last) begin
                     state    <= StDone;
                     in_ready <= 1'b0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end

            StDumpRd: begin
               out_data  <= rf_rd1;
               out_valid <= 1'b1;
               state     <= StDumpWait;
            end

            StDumpWait: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (at_last) begin
                     state <= StDone;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= StDumpRd;
                  end
               end
            end

            StDone: begin
               // busy stays high across the done pulse; it drops one cycle later.
               done  <= 1'b1;
               state <= StIdle;
            end

            default: begin
               state     <= StIdle;
               idx       <= FirstIdx;
               busy      <= 1'b0;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_loader.sv
module tb_regfile_loader;

   localparam int FIRST = 1;
   localparam int LAST  = 31;

   logic        clk = 1'b0;
   logic        reset, start_load, start_dump, abort;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data, rf_wd3, rf_rd1;
   logic [4:0]  rf_a3, rf_a1;
   logic        rf_we, busy, done;

   int checks = 0;
   int errors = 0;

   // Environment register file (what the DUT talks to) and the reference copy.
   logic [31:0] rf [32];
   logic [31:0] exp_rf [32];
   logic        rf_clear = 1'b0;

   always #5 clk = ~clk;

   regfile_loader #(
      .FIRST_REG(FIRST),
      .LAST_REG (LAST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start_load(start_load),
      .start_dump(start_dump),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .rf_a3     (rf_a3),
      .rf_wd3    (rf_wd3),
      .rf_we     (rf_we),
      .rf_a1     (rf_a1),
      .rf_rd1    (rf_rd1),
      .busy      (busy),
      .done      (done)
   );

   always @(posedge clk) begin
      if (rf_clear) begin
         for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : 32'hA5A5_0000 + 32'(i);
      end else if (rf_we && rf_a3 != 5'd0) begin
         rf[rf_a3] <= rf_wd3;
      end
   end

   always_comb rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : rf[rf_a1];

   task automatic pulse_start(input logic ld, input logic dp);
      @(negedge clk);
      start_load = ld;
      start_dump = dp;
      @(negedge clk);
      start_load = 1'b0;
      start_dump = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rf_clear = 1'b1;
      repeat (2) @(negedge clk);
      rf_clear = 1'b0;
      for (int i = 0; i < 32; i++) exp_rf[i] = (i == 0) ? 32'd0 : 32'hA5A5_0000 + 32'(i);
      checks++;
      if ({busy, done, in_ready, out_valid, rf_we} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 00000", {busy, done, in_ready, out_valid, rf_we});
      end
      checks++;
      if ({out_data, rf_a3, rf_wd3} !== 69'd0) begin
         errors++;
         $display("FAIL reset_data: got out_data=%h rf_a3=%0d rf_wd3=%h required zeros",
                  out_data, rf_a3, rf_wd3);
      end
      checks++;
      if (rf_a1 !== 5'(FIRST)) begin
         errors++;
         $display("FAIL reset_idx: got rf_a1=%0d required %0d", rf_a1, FIRST);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Load x1..x31 with 0x100+i, in_valid held high.
   task automatic test_load_full();
      int ptr = FIRST;
      int wr_cnt = 0, done_cnt = 0, last_wr = -1, done_cyc = -1;
      logic acc, exp_rdy;
      logic [4:0] ea;
      logic [31:0] ed;
      pulse_start(1'b1, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL load_busy: got %b required 1", busy);
      end
      for (int cyc = 0; cyc < 40; cyc++) begin
         in_valid = 1'b1;
         in_data  = 32'h100 + 32'(ptr);
         exp_rdy  = (ptr <= LAST);
         acc      = exp_rdy;
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL load_in_ready cyc %0d: got %b required %b", cyc, in_ready, exp_rdy);
         end
         if (acc) begin
            ea = 5'(ptr);
            ed = in_data;
            exp_rf[ptr] = in_data;
            ptr++;
         end
         @(negedge clk);
         checks++;
         if (rf_we !== acc || (acc && {rf_a3, rf_wd3} !== {ea, ed})) begin
            errors++;
            $display("FAIL load_write cyc %0d: got we=%b a3=%0d wd3=%h required we=%b a3=%0d wd3=%h",
                     cyc, rf_we, rf_a3, rf_wd3, acc, ea, ed);
         end
         if (rf_we) begin
            wr_cnt++;
            last_wr = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (wr_cnt != LAST - FIRST + 1 || done_cnt != 1) begin
         errors++;
         $display("FAIL load_counts: got writes=%0d dones=%0d required %0d and 1",
                  wr_cnt, done_cnt, LAST - FIRST + 1);
      end
      checks++;
      if (done_cyc != last_wr + 1) begin
         errors++;
         $display("FAIL load_done_timing: got done cycle %0d required %0d", done_cyc, last_wr + 1);
      end
      checks++;
      if (rf[4] !== 32'h104) begin
         errors++;
         $display("FAIL load_readback_x4: got %h required 00000104", rf[4]);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL load_end_busy: got %b required 0", busy);
      end
   endtask

   // Full dump with out_ready held high: one word every two cycles, then done.
   task automatic test_dump_full();
      int n = 0, prev = -1, gap_bad = 0, done_cnt = 0, done_cyc = -1;
      logic [31:0] ev;
      out_ready = 1'b1;
      pulse_start(1'b0, 1'b1);
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            ev = (n <= LAST - FIRST) ? exp_rf[FIRST + n] : 32'hDEAD_BEEF;
            checks++;
            if (out_data !== ev) begin
               errors++;
               $display("FAIL dump_word %0d: got %h required %h", n, out_data, ev);
            end
            if (prev >= 0 && cyc - prev != 2) gap_bad++;
            prev = cyc;
            n++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
      checks++;
      if (n != LAST - FIRST + 1 || gap_bad != 0) begin
         errors++;
         $display("FAIL dump_stream: got words=%0d bad_gaps=%0d required %0d and 0",
                  n, gap_bad, LAST - FIRST + 1);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != prev + 2) begin
         errors++;
         $display("FAIL dump_done: got count=%0d cycle=%0d required 1 at %0d",
                  done_cnt, done_cyc, prev + 2);
      end
   endtask

   // out_ready low for 5 cycles while word 3 (x3) is presented.
   task automatic test_dump_stall();
      int n = 0, stalls = 0, done_cnt = 0;
      logic [31:0] ev;
      out_ready = 1'b1;
      pulse_start(1'b0, 1'b1);
      for (int cyc = 0; cyc < 90; cyc++) begin
         if (out_valid && n == 2 && stalls < 5) begin
            out_ready = 1'b0;
            stalls++;
            checks++;
            if (out_data !== exp_rf[FIRST + 2]) begin
               errors++;
               $display("FAIL stall_hold %0d: got %h required %h", stalls, out_data, exp_rf[FIRST + 2]);
            end
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            ev = (n <= LAST - FIRST) ? exp_rf[FIRST + n] : 32'hDEAD_BEEF;
            checks++;
            if (out_data !== ev) begin
               errors++;
               $display("FAIL stall_word %0d: got %h required %h", n, out_data, ev);
            end
            n++;
         end
         if (done) done_cnt++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      checks++;
      if (n != LAST - FIRST + 1 || stalls != 5 || done_cnt != 1) begin
         errors++;
         $display("FAIL stall_summary: got words=%0d stalls=%0d dones=%0d required %0d, 5, 1",
                  n, stalls, done_cnt, LAST - FIRST + 1);
      end
   endtask

   // Simultaneous starts pick load; abort beats a start in idle.
   task automatic test_simul_start();
      pulse_start(1'b1, 1'b1);
      checks++;
      if ({in_ready, busy, out_valid} !== 3'b110) begin
         errors++;
         $display("FAIL simul_start: got ready/busy/valid=%b required 110", {in_ready, busy, out_valid});
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({in_ready, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL simul_abort: got ready/busy/done=%b required 000", {in_ready, busy, done});
      end
      abort = 1'b1;
      start_dump = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start_dump = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, out_valid, in_ready} !== 3'b000) begin
         errors++;
         $display("FAIL abort_priority: got busy/valid/ready=%b required 000", {busy, out_valid, in_ready});
      end
   endtask

   // Ten beats with random gaps and data, then abort with a beat on the wire.
   task automatic test_abort_load();
      int ptr = FIRST, bad = 0, done_cnt = 0;
      logic acc;
      logic [4:0] ea;
      logic [31:0] ed;
      pulse_start(1'b1, 1'b0);
      for (int cyc = 0; cyc < 100 && ptr < FIRST + 10; cyc++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = $urandom;
         acc      = in_valid;
         if (acc) begin
            ea = 5'(ptr);
            ed = in_data;
            exp_rf[ptr] = in_data;
            ptr++;
         end
         @(negedge clk);
         checks++;
         if (rf_we !== acc || (acc && {rf_a3, rf_wd3} !== {ea, ed})) begin
            errors++;
            $display("FAIL abort_load_write cyc %0d: got we=%b a3=%0d required we=%b a3=%0d",
                     cyc, rf_we, rf_a3, acc, ea);
         end
      end
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hBAD0_BAD0;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({rf_we, busy, in_ready, done} !== 4'b0000) begin
         errors++;
         $display("FAIL abort_outputs: got we/busy/ready/done=%b required 0000",
                  {rf_we, busy, in_ready, done});
      end
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         if (done || rf_we) done_cnt++;
      end
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d done/we cycles required 0", done_cnt);
      end
      for (int i = 0; i < 32; i++) if (rf[i] !== exp_rf[i]) bad++;
      checks++;
      if (bad != 0 || rf[FIRST + 10] !== exp_rf[FIRST + 10]) begin
         errors++;
         $display("FAIL abort_regs: got %0d wrong registers, x11=%h required x11=%h",
                  bad, rf[FIRST + 10], exp_rf[FIRST + 10]);
      end
   endtask

   task automatic test_random_load();
      int ptr = FIRST, done_cnt = 0, bad = 0;
      logic acc, exp_rdy;
      logic [4:0] ea;
      logic [31:0] ed;
      pulse_start(1'b1, 1'b0);
      for (int cyc = 0; cyc < 200; cyc++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = $urandom;
         exp_rdy  = (ptr <= LAST);
         acc      = in_valid && exp_rdy;
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rload_in_ready cyc %0d: got %b required %b", cyc, in_ready, exp_rdy);
         end
         if (acc) begin
            ea = 5'(ptr);
            ed = in_data;
            exp_rf[ptr] = in_data;
            ptr++;
         end
         @(negedge clk);
         checks++;
         if (rf_we !== acc || (acc && {rf_a3, rf_wd3} !== {ea, ed})) begin
            errors++;
            $display("FAIL rload_write cyc %0d: got we=%b a3=%0d wd3=%h required we=%b a3=%0d wd3=%h",
                     cyc, rf_we, rf_a3, rf_wd3, acc, ea, ed);
         end
         if (done) done_cnt++;
         if (ptr > LAST && !busy) break;
      end
      in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 32; i++) if (rf[i] !== exp_rf[i]) bad++;
      checks++;
      if (done_cnt != 1 || bad != 0) begin
         errors++;
         $display("FAIL rload_end: got dones=%0d wrong_regs=%0d required 1 and 0", done_cnt, bad);
      end
   endtask

   task automatic test_random_dump();
      int n = 0, done_cnt = 0;
      logic held = 1'b0;
      logic [31:0] held_val = '0, ev;
      pulse_start(1'b0, 1'b1);
      for (int cyc = 0; cyc < 300 && done_cnt == 0; cyc++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (held && out_valid) begin
            checks++;
            if (out_data !== held_val) begin
               errors++;
               $display("FAIL rdump_hold cyc %0d: got %h required %h", cyc, out_data, held_val);
            end
         end
         held = 1'b0;
         if (out_valid && out_ready) begin
            ev = (n <= LAST - FIRST) ? exp_rf[FIRST + n] : 32'hDEAD_BEEF;
            checks++;
            if (out_data !== ev) begin
               errors++;
               $display("FAIL rdump_word %0d: got %h required %h", n, out_data, ev);
            end
            n++;
         end else if (out_valid) begin
            held = 1'b1;
            held_val = out_data;
         end
         if (done) done_cnt++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      checks++;
      if (n != LAST - FIRST + 1 || done_cnt != 1) begin
         errors++;
         $display("FAIL rdump_end: got words=%0d dones=%0d required %0d and 1",
                  n, done_cnt, LAST - FIRST + 1);
      end
      repeat (2) @(negedge clk);
   endtask

   // Reset while a word is waiting, then a fresh dump must start at x1.
   task automatic test_reset_dump();
      int waited = 0;
      out_ready = 1'b0;
      pulse_start(1'b0, 1'b1);
      while (!out_valid && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rdump_reach_wait: got out_valid=%b required 1", out_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checks++;
      if ({busy, done, in_ready, out_valid, rf_we, out_data, rf_a3, rf_wd3} !== 74'd0 ||
          rf_a1 !== 5'(FIRST)) begin
         errors++;
         $display("FAIL reset_mid_dump: got busy=%b valid=%b data=%h a1=%0d required 0,0,0,%0d",
                  busy, out_valid, out_data, rf_a1, FIRST);
      end
      out_ready = 1'b1;
      pulse_start(1'b0, 1'b1);
      waited = 0;
      while (!out_valid && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_rf[FIRST]) begin
         errors++;
         $display("FAIL restart_dump: got valid=%b data=%h required 1 and %h",
                  out_valid, out_data, exp_rf[FIRST]);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      start_load = 1'b0;
      start_dump = 1'b0;
      abort      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      test_reset();
      test_load_full();
      test_dump_full();
      test_dump_stall();
      test_simul_start();
      test_abort_load();
      test_random_load();
      test_random_dump();
      test_reset_dump();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_loader.md
REGFILE_LOADER -- requirements
Module: regfile_loader

Interface
REQ-001 Parameter FIRST_REG, default 1, first register index loaded/dumped (x0 never written).
REQ-002 Parameter LAST_REG, default 31, last register index loaded/dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start_load  input  1  one-cycle request to enter load mode.
REQ-006 start_dump  input  1  one-cycle request to enter dump mode.
REQ-007 abort  input  1  terminate any operation, return to idle.
REQ-008 in_valid  input  1  / in_data  input  32  / in_ready  output  1  load stream, valid/ready handshake.
REQ-009 out_valid  output  1  / out_data  output  32  / out_ready  input  1  dump stream, valid/ready handshake.
REQ-010 rf_a3  output  5  / rf_wd3  output  32  / rf_we  output  1  register-file write port drive.
REQ-011 rf_a1  output  5  register-file read address; rf_rd1  input  32  combinational read data.
REQ-012 busy  output  1  high in any non-idle state; core stalls while high.
REQ-013 done  output  1  one-cycle pulse on completion of load or dump.

Function
REQ-014 States: IDLE, LOAD, DUMP_RD, DUMP_WAIT, DONE; 5-bit index counter idx.
REQ-015 IDLE: start_load -> LOAD, idx=FIRST_REG; else start_dump -> DUMP_RD, idx=FIRST_REG; simultaneous starts: load wins.
REQ-016 Starts while not IDLE are ignored.
REQ-017 LOAD: in_ready=1; beat accepted when in_valid && in_ready.
REQ-018 Accepted beat: next cycle rf_we=1, rf_a3=idx-at-accept, rf_wd3=in_data-at-accept (registered, latency 1); rf_we=0 otherwise.
REQ-019 LOAD: idx increments per accepted beat; beat at idx==LAST_REG -> DONE; in_ready=0 from the following cycle.
REQ-020 in_valid low in LOAD: idle wait, no write, no timeout.
REQ-021 in_ready=0 in every state except LOAD; in_data ignored outside LOAD.
REQ-022 rf_a1 = idx at all times (registered counter output).
REQ-023 DUMP_RD: out_data <= rf_rd1, out_valid <= 1, -> DUMP_WAIT.
REQ-024 DUMP_WAIT: out_valid, out_data held stable until out_ready; on handshake out_valid <= 0; idx==LAST_REG -> DONE, else idx+1 -> DUMP_RD.
REQ-025 Dump throughput: one word per 2 cycles at out_ready=1.
REQ-026 DONE: done=1 for exactly one cycle, busy=1, -> IDLE.
REQ-027 abort (any state): next cycle IDLE, in_ready=0, out_valid=0, rf_we=0, no done pulse; a write registered from a beat accepted in the abort cycle is suppressed.
REQ-028 abort has priority over start_load/start_dump in IDLE.
REQ-029 idx never exceeds LAST_REG; no wrap-around.

Reset
REQ-030 reset low at rising edge: state IDLE, idx=FIRST_REG, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, rf_we=0, rf_a3=0, rf_wd3=0.
REQ-031 Reset mid-operation: behaves as abort; partially loaded registers keep written values.

Structure
REQ-032 State encoding and default FIRST_REG/LAST_REG constants reside in shared package rv32_pkg.
REQ-033 Single module, no sub-modules; instantiated beside the register file with a mux on its write port gated by busy.

Verification
REQ-034 Load x1..x31 with values 0x100+i, in_valid always 1 -> 31 rf_we pulses, rf_a3=1..31, done one cycle after write 31; readback of x4=0x104.
REQ-035 Dump after load, out_ready=1 -> 31 words 0x101..0x11F in order, 2 cycles apart, then done.
REQ-036 Dump with out_ready low 5 cycles on word 3 -> out_data=0x103 held stable, no skip, no duplicate.
REQ-037 start_load and start_dump same cycle -> LOAD entered, in_ready=1 next cycle.
REQ-038 abort after 10 load beats -> rf_we=0 next cycle, busy=0, no done; x1..x10 written, x11 unchanged.
REQ-039 reset low during DUMP_WAIT -> all outputs at reset values next cycle; subsequent start_dump restarts at x1.
